hc595_test_drive: RTL and testbench



---
 rtl/hc595_test_drive_pkg.sv | 26 ++
 rtl/hc595_test_drive_seg7_decode.sv | 15 +
 rtl/hc595_test_drive.sv | 145 ++++++++++++++
 tb/tb_hc595_test_drive.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hc595_test_drive_pkg.sv
// hc595_test_drive_pkg
// Shared definitions for the 74HC595 test-pattern driver:
//   state_t      - frame sequencer states
//   LATCH_CYCLES - length of the storage-clock window in sys_clk cycles
//   LATCH_HIGH   - number of those cycles with rclk held high
//   SEG_CODES    - common-anode, active-low 7-segment codes for hex 0..F
package hc595_test_drive_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int LATCH_CYCLES = 4;
  localparam int LATCH_HIGH   = 2;

  // Packed so that SEG_CODES[n] is the code for hex digit n; the
  // concatenation is therefore written from F down to 0.
  localparam logic [15:0][7:0] SEG_CODES = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/hc595_test_drive_seg7_decode.sv
// seg7_decode
// Purely combinational hex-to-7-segment lookup for a common-anode display.
// Ports:
//   hex - 4-bit value to display
//   seg - active-low segment code (bit 7 = decimal point, always off)
module seg7_decode
  import hc595_test_drive_pkg::*;
(
  input  logic [3:0] hex,
  output logic [7:0] seg
);

  assign seg = SEG_CODES[hex];

endmodule

// File: rtl/hc595_test_drive.sv
// hc595_test_drive
// Free-running pattern generator for two daisy-chained 74HC595s feeding a
// 7-segment display. Each frame shifts {digit_select, segments} out MSB
// first, pulses the storage clock, idles for a gap, then moves on to the
// next of 16 frames.
// Ports:
//   sys_clk  - system clock, all logic on the rising edge
//   rst_n    - synchronous reset, active HIGH despite the name
//   srclk    - 595 shift clock (data sampled on its rising edge)
//   rclk     - 595 storage clock (outputs update on its rising edge)
//   data_ser - serial data into the first 595
module hc595_test_drive
  import hc595_test_drive_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int GAP_CYCLES = 16,
  parameter int FRAME_BITS = 16
) (
  input  logic sys_clk,
  input  logic rst_n,
  output logic srclk,
  output logic rclk,
  output logic data_ser
);

  localparam int PH_W     = $clog2(BIT_CYCLES);
  localparam int BIT_W    = $clog2(FRAME_BITS);
  localparam int WAIT_MAX = (GAP_CYCLES > LATCH_CYCLES) ? GAP_CYCLES : LATCH_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX);

  localparam logic [PH_W-1:0]   PH_LAST    = PH_W'(BIT_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_RISE    = PH_W'(BIT_CYCLES / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(FRAME_BITS - 1);
  localparam logic [WAIT_W-1:0] LATCH_LAST = WAIT_W'(LATCH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] LATCH_HI   = WAIT_W'(LATCH_HIGH);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(GAP_CYCLES - 1);

  state_t                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [3:0]            frame_q, frame_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  srclk_d, rclk_d, data_d;

  logic [7:0]            seg_code;
  logic [7:0]            digit_code;

  seg7_decode u_seg7_decode (
    .hex (frame_q),
    .seg (seg_code)
  );

  // One-hot digit select walks across the 8 digits as the frame advances.
  assign digit_code = 8'h01 << frame_q[2:0];

  // Next-state logic. The pin values are derived from the *next* state and
  // counters so the output flops line up exactly with the phase windows
  // instead of lagging them by a cycle.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    wait_d  = wait_q;
    frame_d = frame_q;
    shift_d = shift_q;

    unique case (state_q)
      LOAD: begin
        shift_d = {digit_code, seg_code};
        phase_d = '0;
        bit_d   = '0;
        wait_d  = '0;
        state_d = SHIFT;
      end

      SHIFT: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            wait_d  = '0;
            state_d = LATCH;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      LATCH: begin
        if (wait_q == LATCH_LAST) begin
          wait_d  = '0;
          state_d = GAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      GAP: begin
        if (wait_q == GAP_LAST) begin
          wait_d  = '0;
          frame_d = frame_q + 4'd1;
          state_d = LOAD;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: state_d = LOAD;
    endcase

    srclk_d = (state_d == SHIFT) && (phase_d >= PH_RISE);
    rclk_d  = (state_d == LATCH) && (wait_d < LATCH_HI);
    data_d  = (state_d == SHIFT) && shift_d[FRAME_BITS-1];
  end

  // State, counters, shift register and the registered pin drivers.
  // Reset abandons any frame in progress so it can never be latched.
  always_ff @(posedge sys_clk) begin
    if (rst_n) begin
      state_q  <= LOAD;
      phase_q  <= '0;
      bit_q    <= '0;
      wait_q   <= '0;
      frame_q  <= '0;
      shift_q  <= '0;
      srclk    <= 1'b0;
      rclk     <= 1'b0;
      data_ser <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      wait_q   <= wait_d;
      frame_q  <= frame_d;
      shift_q  <= shift_d;
      srclk    <= srclk_d;
      rclk     <= rclk_d;
      data_ser <= data_d;
    end
  end

endmodule

// File: tb/tb_hc595_test_drive.sv
// tb_hc595_test_drive
// Self-checking bench for hc595_test_drive. A negedge monitor rebuilds each
// 16-bit word from srclk rising edges and compares it on every rclk rising
// edge against a scoreboard queue filled by the stimulus tasks.
module tb_hc595_test_drive;

  localparam int FRAME_LEN   = 85;
  localparam int LATCH_AT    = 65;
  localparam int POST_LATCH  = 20;
  localparam int RUN_CYCLES  = 5000;

  localparam logic [7:0] SEG_TB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic sys_clk;
  logic rst_n;
  logic srclk;
  logic rclk;
  logic data_ser;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb[$];
  int          rise_log[$];

  int          cycle       = 0;
  bit          armed       = 1'b0;
  logic        rst_prev    = 1'b0;
  logic        srclk_q     = 1'b0;
  logic        rclk_q      = 1'b0;
  logic        data_q      = 1'b0;
  logic [15:0] accum       = '0;
  int          srclk_cnt   = 0;
  int          last_rclk   = -1;
  int          last_rise   = -100;
  int          last_change = -100;
  int          rclk_start  = 0;

  hc595_test_drive #(
    .BIT_CYCLES (4),
    .GAP_CYCLES (16),
    .FRAME_BITS (16)
  ) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .srclk    (srclk),
    .rclk     (rclk),
    .data_ser (data_ser)
  );

  // 50 MHz system clock.
  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d",
               tag, observed, expected, cycle);
    end
  endtask

  // Independent reference for frame f: one-hot digit plus segment code.
  function automatic logic [15:0] expectedWord(input int f);
    logic [7:0] digit;
    digit = 8'h01 << (f % 8);
    return {digit, SEG_TB[f % 16]};
  endfunction

  // Holds reset for n rising edges; returns just after the last of them.
  task automatic resetDut(input int n);
    @(posedge sys_clk);
    #1 rst_n = 1'b1;
    repeat (n) @(posedge sys_clk);
    #1 rst_n = 1'b0;
  endtask

  // Waits (bounded) for every queued word to be latched.
  task automatic waitDrain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() > 0; i++) @(posedge sys_clk);
    checkOutput(tag, sb.size(), 0);
  endtask

  // Resets the DUT, then expects `frames` consecutive frames from frame 0.
  task automatic applyStimulus(input int reset_cycles, input int frames);
    resetDut(reset_cycles);
    for (int k = 0; k < frames; k++) sb.push_back(expectedWord(k));
    waitDrain("drain", frames * FRAME_LEN + 200);
  endtask

  // Per-cycle monitor. Cycles touched by reset are skipped for protocol
  // checks and wipe any partially collected word.
  always @(negedge sys_clk) begin
    cycle++;
    if (armed) begin
      checkOutput("no_x", {31'd0, $isunknown({srclk, rclk, data_ser})}, 0);
      checkOutput("overlap", {31'd0, srclk & rclk}, 0);
      if (rst_prev) checkOutput("reset_outputs", {29'd0, srclk, rclk, data_ser}, 0);

      if (rst_n || rst_prev) begin
        accum       = '0;
        srclk_cnt   = 0;
        last_rclk   = -1;
        last_rise   = -100;
        last_change = -100;
      end else begin
        if (srclk && !srclk_q) begin
          checkOutput("setup", {31'd0, (cycle - last_change) >= 2}, 1);
          accum     = {accum[14:0], data_ser};
          srclk_cnt++;
          last_rise = cycle;
        end
        if (data_ser != data_q) begin
          checkOutput("hold", {31'd0, (cycle - last_rise) >= 2}, 1);
          last_change = cycle;
        end
        if (rclk && !rclk_q) begin
          rise_log.push_back(cycle);
          if (sb.size() == 0) begin
            checkOutput("unexpected_latch", {16'd0, accum}, 32'hFFFF_FFFF);
          end else begin
            checkOutput("word", {16'd0, accum}, {16'd0, sb.pop_front()});
          end
          checkOutput("srclk_count", srclk_cnt, 16);
          if (last_rclk >= 0) checkOutput("latch_period", cycle - last_rclk, FRAME_LEN);
          last_rclk  = cycle;
          rclk_start = cycle;
          srclk_cnt  = 0;
        end
        if (!rclk && rclk_q) checkOutput("rclk_width", cycle - rclk_start, 2);
      end
    end else if (rst_prev) begin
      armed = 1'b1;
    end
    srclk_q  = srclk;
    rclk_q   = rclk;
    data_q   = data_ser;
    rst_prev = rst_n;
  end

  // Hard stop in case something stalls the stimulus.
  initial begin
    #(30000 * 20);
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int release_mark;
    int complete;

    rst_n = 1'b1;

    // Power-up: first frames compared against literal words.
    $display("[TB] reset and first four frames");
    resetDut(5);
    sb.push_back(16'h01C0);
    sb.push_back(16'h02F9);
    sb.push_back(16'h04A4);
    sb.push_back(16'h08B0);
    waitDrain("drain_first", 4 * FRAME_LEN + 200);

    // Full counter sweep including the 15 -> 0 wrap.
    $display("[TB] seventeen frames");
    applyStimulus(3, 17);

    // Abort in the middle of frame 3's shift; it must never be latched.
    $display("[TB] mid-frame reset");
    resetDut(2);
    for (int k = 0; k < 3; k++) sb.push_back(expectedWord(k));
    repeat (3 * FRAME_LEN + 29) @(posedge sys_clk);
    checkOutput("pre_abort_drain", sb.size(), 0);
    resetDut(1);
    sb.push_back(16'h01C0);
    waitDrain("post_abort_drain", FRAME_LEN + 100);

    // Long run: a frame counts as complete when its latch and the 20
    // cycles that follow (latch window + gap) fit inside the window.
    $display("[TB] long run");
    resetDut(5);
    release_mark = cycle + 1;
    rise_log.delete();
    for (int k = 0; k < 59; k++) sb.push_back(expectedWord(k));
    repeat (RUN_CYCLES) @(posedge sys_clk);
    complete = 0;
    foreach (rise_log[i]) begin
      if (rise_log[i] >= release_mark &&
          rise_log[i] - release_mark + POST_LATCH <= RUN_CYCLES) complete++;
    end
    checkOutput("complete_frames", complete, 58);
    checkOutput("first_latch_offset",
                (rise_log.size() > 0) ? rise_log[0] - release_mark : -1, LATCH_AT);
    checkOutput("long_drain", sb.size(), 0);

    resetDut(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
